// File: rtl/kernel_window_gen.sv
// kernel_window_gen
// Assembles a 7x7 sliding window from a raster-order pixel stream for the
// bilateral filter kernel product stage. Six line buffers hold the previous
// six lines; a 7x7 register window shifts left one column per accepted pixel.
// Only full in-image windows are flagged valid (no border padding).
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   pixel_in      input pixel word
//   pixel_valid   pixel_in accepted this cycle (no backpressure)
//   pixel_sof     with pixel_valid, forces the pixel to (row 0, col 0)
//   window        49 words, window[i*7+j] = pixel(r-6+i, c-6+j)
//   window_valid  window holds a complete in-image kernel this cycle
//   window_row    centre row of the current window
//   window_col    centre column of the current window
//   frame_done    one-cycle pulse after the last pixel of a frame
module kernel_window_gen #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pixel_valid,
    input  logic              pixel_sof,
    output logic [DATA_W-1:0] window [48:0],
    output logic              window_valid,
    output logic [11:0]       window_row,
    output logic [11:0]       window_col,
    output logic              frame_done
);

    localparam int          AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [11:0] LAST_COL = 12'(IMG_W - 1);
    localparam logic [11:0] LAST_ROW = 12'(IMG_H - 1);

    // Reset asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst_int = rst_sync[1];

    logic [11:0] col;
    logic [11:0] row;
    logic [11:0] eff_col;
    logic [11:0] eff_row;
    logic [AW-1:0] addr;

    // A start-of-frame pixel overrides whatever the counters say.
    assign eff_col = pixel_sof ? 12'd0 : col;
    assign eff_row = pixel_sof ? 12'd0 : row;
    assign addr    = eff_col[AW-1:0];

    // Line buffers: buffer k holds line r-1-k. Not reset; every location is
    // rewritten before a window that depends on it can be flagged valid.
    logic [DATA_W-1:0] lb_mem [6][IMG_W];
    logic [DATA_W-1:0] lb_rd  [6];

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            lb_rd[k] = lb_mem[k][addr];
        end
    end

    // Read-then-write shift chain: each buffer takes the old value of the one
    // above it at the same column.
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            lb_mem[0][addr] <= pixel_in;
            for (int k = 1; k < 6; k++) begin
                lb_mem[k][addr] <= lb_mem[k-1][addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            col          <= '0;
            row          <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            window_row   <= '0;
            window_col   <= '0;
            for (int n = 0; n < 49; n++) begin
                window[n] <= '0;
            end
        end else begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (pixel_valid) begin
                if (eff_col == LAST_COL) begin
                    col <= '0;
                    if (eff_row == LAST_ROW) begin
                        row        <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        row <= eff_row + 12'd1;
                    end
                end else begin
                    col <= eff_col + 12'd1;
                    row <= eff_row;
                end

                for (int i = 0; i < 7; i++) begin
                    for (int j = 0; j < 6; j++) begin
                        window[i*7+j] <= window[i*7+j+1];
                    end
                end
                // New right column: oldest line at the top, live pixel at the bottom.
                for (int i = 0; i < 6; i++) begin
                    window[i*7+6] <= lb_rd[5-i];
                end
                window[48] <= pixel_in;

                // Windows with c<6 would wrap into the previous line.
                if (eff_row >= 12'd6 && eff_col >= 12'd6) begin
                    window_valid <= 1'b1;
                    window_row   <= eff_row - 12'd3;
                    window_col   <= eff_col - 12'd3;
                end
            end
        end
    end

endmodule

// File: tb/tb_kernel_window_gen.sv
module tb_kernel_window_gen;

    localparam int W = 8;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_sof = 1'b0;
    logic [31:0] window [48:0];
    logic        window_valid;
    logic [11:0] window_row;
    logic [11:0] window_col;
    logic        frame_done;

    kernel_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .pixel_in(pixel_in),
        .pixel_valid(pixel_valid),
        .pixel_sof(pixel_sof),
        .window(window),
        .window_valid(window_valid),
        .window_row(window_row),
        .window_col(window_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [11:0]       row;
        logic [11:0]       col;
        logic [48:0][31:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   fd_q[$];

    int checks = 0;
    int passes = 0;
    int win_seen = 0;
    int fd_seen = 0;

    // Reference model: the current frame as a plain 2D image.
    logic [31:0] img [H][W];
    int m_row = 0;
    int m_col = 0;

    logic [31:0] first_w [49];
    bit   have_first = 0;
    logic sampled_pv = 1'b0;
    exp_t mon_e;
    int   mon_k;
    int   mon_fd;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    endtask

    task automatic model_step(input logic pv, input logic sof, input logic [31:0] d);
        exp_t e;
        if (pv) begin
            if (sof) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = d;
            if (m_row >= 6 && m_col >= 6) begin
                e.row = 12'(m_row - 3);
                e.col = 12'(m_col - 3);
                for (int i = 0; i < 7; i++)
                    for (int j = 0; j < 7; j++)
                        e.w[i*7+j] = img[m_row-6+i][m_col-6+j];
                exp_q.push_back(e);
            end
            if (m_col == W - 1) begin
                m_col = 0;
                if (m_row == H - 1) begin
                    m_row = 0;
                    fd_q.push_back(cyc + 1);
                end else begin
                    m_row++;
                end
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic drive(input logic pv, input logic sof, input logic [31:0] d);
        @(posedge clk);
        #1;
        pixel_valid = pv;
        pixel_sof   = sof;
        pixel_in    = d;
        model_step(pv, sof, d);
    endtask

    // data_mode 0: value = index in frame; 1: random.
    // stall_mode 0: back-to-back; 1: idle every other cycle; 2: random idles
    // (with stray pixel_sof on idle cycles, which must be ignored).
    task automatic send_frame(input int npix, input bit sof_first, input int data_mode, input int stall_mode);
        logic [31:0] d;
        for (int i = 0; i < npix; i++) begin
            if (stall_mode == 1 && i > 0) drive(1'b0, 1'b0, $urandom);
            if (stall_mode == 2) begin
                repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom_range(0, 1)), $urandom);
            end
            d = (data_mode == 0) ? 32'(i) : $urandom;
            drive(1'b1, sof_first && i == 0, d);
        end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || fd_q.size() != 0) && n < 30) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check("pending windows after drain", 64'(exp_q.size()), 64'd0);
        check("pending frame_done after drain", 64'(fd_q.size()), 64'd0);
    endtask

    always @(posedge clk) sampled_pv <= pixel_valid;

    always @(negedge clk) begin
        if (!rst) begin
            if (!sampled_pv) check("window_valid after idle cycle", 64'(window_valid), 64'd0);
            if (window_valid) begin
                win_seen++;
                if (!have_first) begin
                    for (int n = 0; n < 49; n++) first_w[n] = window[n];
                    have_first = 1;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected window", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("window_row", 64'(window_row), 64'(mon_e.row));
                    check("window_col", 64'(window_col), 64'(mon_e.col));
                    mon_k = 0;
                    for (int n = 48; n >= 0; n--) if (window[n] !== mon_e.w[n]) mon_k = n;
                    check("window word", 64'(window[mon_k]), 64'(mon_e.w[mon_k]));
                end
            end
            if (frame_done) begin
                fd_seen++;
                if (fd_q.size() == 0) begin
                    check("unexpected frame_done", 64'(fd_q.size()), 64'd1);
                end else begin
                    mon_fd = fd_q.pop_front();
                    check("frame_done cycle", 64'(cyc), 64'(mon_fd));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, fb;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset window_valid", 64'(window_valid), 64'd0);
        check("reset frame_done", 64'(frame_done), 64'd0);
        check("reset window_row", 64'(window_row), 64'd0);
        check("reset window_col", 64'(window_col), 64'd0);
        check("reset window[0]", 64'(window[0]), 64'd0);
        check("reset window[48]", 64'(window[48]), 64'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Ramp frame, back-to-back.
        wb = win_seen; fb = fd_seen;
        send_frame(64, 1'b1, 0, 0);
        drain();
        check("ramp frame window count", 64'(win_seen - wb), 64'd4);
        check("ramp frame frame_done count", 64'(fd_seen - fb), 64'd1);
        check("first window[0]", 64'(first_w[0]), 64'd0);
        check("first window[6]", 64'(first_w[6]), 64'd6);
        check("first window[42]", 64'(first_w[42]), 64'd48);
        check("first window[48]", 64'(first_w[48]), 64'd54);

        // Same frame, pixel_valid every other cycle.
        wb = win_seen; fb = fd_seen;
        send_frame(64, 1'b1, 0, 1);
        drain();
        check("stalled frame window count", 64'(win_seen - wb), 64'd4);
        check("stalled frame frame_done count", 64'(fd_seen - fb), 64'd1);

        // Resync: sof at pixel 30, then a fresh frame with sof.
        wb = win_seen; fb = fd_seen;
        send_frame(30, 1'b1, 1, 0);
        send_frame(64, 1'b1, 1, 0);
        drain();
        check("resync window count", 64'(win_seen - wb), 64'd4);
        check("resync frame_done count", 64'(fd_seen - fb), 64'd1);

        // Reset during row 6, right after the (6,6) window appears.
        for (int i = 0; i <= 54; i++) drive(1'b1, i == 0, $urandom);
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        #2;
        check("window_valid before mid-frame rst", 64'(window_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("window_valid after async rst", 64'(window_valid), 64'd0);
        exp_q.delete();
        fd_q.delete();
        m_row = 0;
        m_col = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        wb = win_seen; fb = fd_seen;
        send_frame(64, 1'b0, 0, 0);
        drain();
        check("post-rst window count", 64'(win_seen - wb), 64'd4);
        check("post-rst frame_done count", 64'(fd_seen - fb), 64'd1);

        // Two frames back-to-back, counter wrap only.
        wb = win_seen; fb = fd_seen;
        send_frame(128, 1'b1, 1, 0);
        drain();
        check("two-frame window count", 64'(win_seen - wb), 64'd8);
        check("two-frame frame_done count", 64'(fd_seen - fb), 64'd2);

        // Random data with random stalls and stray idle sof, three frames.
        wb = win_seen; fb = fd_seen;
        send_frame(192, 1'b1, 1, 2);
        drain();
        check("random frames window count", 64'(win_seen - wb), 64'd12);
        check("random frames frame_done count", 64'(fd_seen - fb), 64'd3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
